fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the processor core. It owns the program counter, drives the 12-bit word address into the synchronous `imem` syncram, and pairs each returned 32-bit word with its PC. Fetched instructions queue in a 2-entry buffer and are handed to decode over a valid/ready handshake. A redirect port lets branches and jumps flush the buffer and discard in-flight fetches.

---
 rtl/fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem address and
// queues returned words with their PCs in a 2-entry buffer feeding decode.
module fetch_unit #(
  parameter int unsigned           ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [31:0]       q_imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
);

  logic [ADDR_W-1:0] pc;
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;
  logic [1:0]        count;
  logic [31:0]       tail_instr;
  logic [ADDR_W-1:0] tail_pc;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;

  assign address_imem = redirect_valid ? redirect_pc : pc;
  assign instr_valid  = (count != 2'd0);
  assign pop          = instr_valid & instr_ready & ~redirect_valid;
  assign push         = req_valid & ~redirect_valid;

  // count + req_valid - pop <= 1, rearranged so nothing goes negative
  assign occupancy = {1'b0, count} + {2'b00, req_valid};
  assign issue     = redirect_valid | (occupancy <= (3'd1 + {2'b00, pop}));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else begin
      req_valid <= issue;
      if (issue) begin
        req_pc <= address_imem;
        pc     <= address_imem + ADDR_W'(1);
      end
    end
  end

  // Head entry doubles as the output registers; tail only holds the second word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= 2'd0;
      instr      <= '0;
      instr_pc   <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            instr    <= q_imem;
            instr_pc <= req_pc;
          end else begin
            tail_instr <= q_imem;
            tail_pc    <= req_pc;
          end
        end
        2'b01: begin
          count <= count - 2'd1;
          if (count == 2'd2) begin
            instr    <= tail_instr;
            instr_pc <= tail_pc;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            instr      <= tail_instr;
            instr_pc   <= tail_pc;
            tail_instr <= q_imem;
            tail_pc    <= req_pc;
          end else begin
            instr    <= q_imem;
            instr_pc <= req_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
